vec_serialize: RTL and testbench



---
 rtl/vec_pkg.sv | 15 +
 rtl/vec_serialize_if.sv | 50 +++++
 rtl/vec_serialize.sv | 105 ++++++++++
 tb/tb_vec_serialize.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector datapath units.
// Holds the vector length, the width of an element index, and the
// element-index enum that the vector units also use.
package vec_pkg;

    localparam int VEC_LEN = 3;
    localparam int IDX_W   = $clog2(VEC_LEN);

    typedef enum logic [IDX_W-1:0] {
        ELEM_X = 2'd0,
        ELEM_Y = 2'd1,
        ELEM_Z = 2'd2
    } elem_idx_e;

endpackage

// File: rtl/vec_serialize_if.sv
// Bundle for vec_serialize: a 3-element vector AXI-stream in and a scalar
// AXI-stream out.
//   s_axis_vec_*    : vector input stream (tdata, tvalid, tready)
//   m_axis_result_* : scalar output stream (tdata, tvalid, tready, tlast, tuser)
// Modports:
//   slave  - the serializer: consumes the vector stream, produces the scalar stream
//   master - the environment: produces vectors, consumes scalars
//
// Handshake: a beat transfers on a rising edge where valid && ready. Once
// valid is high, it stays high and the payload stays constant until that
// transfer happens. Valid never depends on ready.
interface vec_serialize_if
    import vec_pkg::*;
#(
    parameter int SIZE = 32
);

    logic [VEC_LEN-1:0][SIZE-1:0] s_axis_vec_tdata;
    logic                         s_axis_vec_tvalid;
    logic                         s_axis_vec_tready;

    logic [SIZE-1:0]              m_axis_result_tdata;
    logic                         m_axis_result_tvalid;
    logic                         m_axis_result_tready;
    logic                         m_axis_result_tlast;
    logic [IDX_W-1:0]             m_axis_result_tuser;

    modport slave (
        input  s_axis_vec_tdata,
        input  s_axis_vec_tvalid,
        output s_axis_vec_tready,
        output m_axis_result_tdata,
        output m_axis_result_tvalid,
        input  m_axis_result_tready,
        output m_axis_result_tlast,
        output m_axis_result_tuser
    );

    modport master (
        output s_axis_vec_tdata,
        output s_axis_vec_tvalid,
        input  s_axis_vec_tready,
        input  m_axis_result_tdata,
        input  m_axis_result_tvalid,
        output m_axis_result_tready,
        input  m_axis_result_tlast,
        input  m_axis_result_tuser
    );

endinterface

// File: rtl/vec_serialize.sv
// vec_serialize: turns a 3-element vector stream into a scalar stream,
// emitting element 0, 1, 2 on consecutive beats. tlast marks element 2, and
// tuser carries the element index.
// A two-slot buffer (active + next) lets a new vector be accepted while the
// current one is still being emitted, so back-to-back vectors produce
// bubble-free output.
// Ports:
//   aclk   - clock, rising edge
//   areset - synchronous, active-high reset
//   bus    - vec_serialize_if.slave (vector in, scalar out)
module vec_serialize
    import vec_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            aclk,
    input  logic            areset,
    vec_serialize_if.slave  bus
);

    logic                         r_active_valid;
    logic [VEC_LEN-1:0][SIZE-1:0] r_active_data;
    logic [IDX_W-1:0]             r_idx;
    logic                         r_next_valid;
    logic [VEC_LEN-1:0][SIZE-1:0] r_next_data;

    logic                         w_active_valid;
    logic [VEC_LEN-1:0][SIZE-1:0] w_active_data;
    logic [IDX_W-1:0]             w_idx;
    logic                         w_next_valid;
    logic [VEC_LEN-1:0][SIZE-1:0] w_next_data;

    logic w_tvalid;
    logic w_tready;
    logic w_out_hs;
    logic w_in_hs;
    logic w_vacate;

    // Input readiness comes only from registered state, so there is no
    // combinational path from the downstream tready to the upstream tready.
    assign w_tready = !r_next_valid && !areset;
    assign w_tvalid = r_active_valid && !areset;

    assign w_out_hs = w_tvalid && bus.m_axis_result_tready;
    assign w_in_hs  = bus.s_axis_vec_tvalid && w_tready;
    assign w_vacate = w_out_hs && (r_idx == ELEM_Z);

    assign bus.s_axis_vec_tready    = w_tready;
    assign bus.m_axis_result_tvalid = w_tvalid;
    assign bus.m_axis_result_tdata  = r_active_data[r_idx];
    assign bus.m_axis_result_tuser  = r_idx;
    assign bus.m_axis_result_tlast  = r_active_valid && (r_idx == ELEM_Z);

    always_comb begin
        w_active_valid = r_active_valid;
        w_active_data  = r_active_data;
        w_idx          = r_idx;
        w_next_valid   = r_next_valid;
        w_next_data    = r_next_data;

        if (w_out_hs) begin
            if (r_idx != ELEM_Z) begin
                w_idx = r_idx + IDX_W'(1);
            end else begin
                w_idx = '0;
                if (r_next_valid) begin
                    w_active_data = r_next_data;
                    w_next_valid  = 1'b0;
                end else begin
                    w_active_valid = 1'b0;
                end
            end
        end

        // An accepted vector implies next is empty (tready requires it), so
        // the promotion above and this write never collide. If the active
        // slot is free or draining this cycle, the input goes straight to
        // active and the element-0 beat follows with no bubble.
        if (w_in_hs) begin
            if (!r_active_valid || (w_vacate && !r_next_valid)) begin
                w_active_data  = bus.s_axis_vec_tdata;
                w_active_valid = 1'b1;
                w_idx          = '0;
            end else begin
                w_next_data  = bus.s_axis_vec_tdata;
                w_next_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_active_valid <= 1'b0;
            r_next_valid   <= 1'b0;
            r_idx          <= '0;
        end else begin
            r_active_valid <= w_active_valid;
            r_next_valid   <= w_next_valid;
            r_idx          <= w_idx;
        end
        r_active_data <= w_active_data;
        r_next_data   <= w_next_data;
    end

endmodule

// File: tb/tb_vec_serialize.sv
// Bench for vec_serialize: the driver pushes the expected scalar beats of each
// accepted vector into exp_q, and a monitor pops and compares every
// transferred output beat.
module tb_vec_serialize;
    import vec_pkg::*;

    localparam int SIZE = 32;
    localparam int EW   = SIZE + IDX_W + 1;

    typedef logic [VEC_LEN-1:0][SIZE-1:0] vec_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    vec_serialize_if #(.SIZE(SIZE)) bus ();

    vec_serialize #(.SIZE(SIZE)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus.slave)
    );

    logic [EW-1:0] exp_q[$];
    int            beat_cyc[$];
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
    int            acc_cyc = 0;
    bit            ready_rand = 1'b0;
    logic          ready_force = 1'b1;

    always @(posedge aclk) cyc = cyc + 1;

    // Downstream ready: either a fixed level or a coin flip per cycle.
    always @(posedge aclk) begin
        #2;
        bus.m_axis_result_tready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model: a vector becomes three scalar beats, in element order, tagged
    // with their index, tlast only on the final element.
    task automatic push_vec(input vec_t v);
        for (int e = 0; e < VEC_LEN; e++) begin
            exp_q.push_back({(e == VEC_LEN - 1), IDX_W'(e), v[e]});
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int e = 0; e < VEC_LEN; e++) v[e] = $urandom;
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic offer(input vec_t v);
        bus.s_axis_vec_tdata  = v;
        bus.s_axis_vec_tvalid = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge aclk);
            if (bus.s_axis_vec_tready === 1'b1) begin
                push_vec(bus.s_axis_vec_tdata);
                acc_cyc = cyc;
                ok = 1'b1;
            end
            @(posedge aclk);
            #1;
        end
        bus.s_axis_vec_tvalid = 1'b0;
        check("accept", 64'(ok), 64'd1);
    endtask

    task automatic send_vec(input vec_t v);
        offer(v);
        wait_accept();
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge aclk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        idle(1);
    endtask

    task automatic check_run(input string name, input int n);
        bit ok;
        ok = 1'b1;
        check({name, "_count"}, 64'(beat_cyc.size()), 64'(n));
        for (int i = 1; i < beat_cyc.size(); i++) begin
            if (beat_cyc[i] != beat_cyc[0] + i) ok = 1'b0;
        end
        check({name, "_no_bubble"}, 64'(ok), 64'd1);
    endtask

    // Monitor: every transferred beat is compared with the scoreboard, and a
    // stalled beat must hold its payload until it transfers.
    logic          held = 1'b0;
    logic [EW-1:0] held_beat;
    always @(negedge aclk) begin
        logic [EW-1:0] got;
        got = {bus.m_axis_result_tlast, bus.m_axis_result_tuser, bus.m_axis_result_tdata};
        if (areset) begin
            held = 1'b0;
        end else begin
            if (held) check("hold_stable", 64'({bus.m_axis_result_tvalid, got}), 64'({1'b1, held_beat}));
            if (bus.m_axis_result_tvalid && bus.m_axis_result_tready) begin
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %0h want no beat (cycle %0d)", got, cyc);
                end else begin
                    check("beat", 64'(got), 64'(exp_q.pop_front()));
                end
            end
            held = bus.m_axis_result_tvalid && !bus.m_axis_result_tready;
            held_beat = got;
        end
    end

    initial begin
        vec_t v;
        bus.s_axis_vec_tvalid = 1'b0;
        bus.s_axis_vec_tdata  = '0;
        areset = 1'b1;
        idle(3);

        // Reset state.
        @(negedge aclk);
        check("rst_tvalid", 64'(bus.m_axis_result_tvalid), 64'd0);
        check("rst_s_tready", 64'(bus.s_axis_vec_tready), 64'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_tvalid", 64'(bus.m_axis_result_tvalid), 64'd0);
        check("post_rst_tlast", 64'(bus.m_axis_result_tlast), 64'd0);
        check("post_rst_tuser", 64'(bus.m_axis_result_tuser), 64'd0);
        check("post_rst_s_tready", 64'(bus.s_axis_vec_tready), 64'd1);
        @(posedge aclk);
        #1;

        // Single known vector: latency 1, three consecutive beats.
        beat_cyc.delete();
        send_vec({32'h40400000, 32'h40000000, 32'h3F800000});
        drain();
        check_run("single", 3);
        if (beat_cyc.size() > 0) check("single_latency", 64'(beat_cyc[0]), 64'(acc_cyc + 1));

        // Three vectors back to back: nine beats without a gap.
        beat_cyc.delete();
        for (int k = 0; k < 3; k++) send_vec(rand_vec());
        drain();
        check_run("b2b", 9);

        // Downstream stalled: two vectors buffered, the third held off.
        beat_cyc.delete();
        ready_force = 1'b0;
        send_vec(rand_vec());
        send_vec(rand_vec());
        offer(rand_vec());
        repeat (3) begin
            @(negedge aclk);
            check("bp_s_tready_low", 64'(bus.s_axis_vec_tready), 64'd0);
            @(posedge aclk);
            #1;
        end
        check("bp_buffered", 64'(exp_q.size()), 64'd6);
        ready_force = 1'b1;
        wait_accept();
        drain();
        check_run("bp_release", 9);

        // New vector accepted on the same edge as the tlast transfer.
        beat_cyc.delete();
        send_vec(rand_vec());
        idle(2);
        send_vec(rand_vec());
        drain();
        check_run("tlast_coincide", 6);
        if (beat_cyc.size() > 2) check("tlast_coincide_edge", 64'(acc_cyc), 64'(beat_cyc[2]));

        // Reset after element 1: nothing stale afterwards, restart at index 0.
        beat_cyc.delete();
        send_vec(rand_vec());
        idle(2);
        areset = 1'b1;
        exp_q.delete();
        @(negedge aclk);
        check("midrst_tvalid", 64'(bus.m_axis_result_tvalid), 64'd0);
        check("midrst_s_tready", 64'(bus.s_axis_vec_tready), 64'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("after_midrst_tvalid", 64'(bus.m_axis_result_tvalid), 64'd0);
        check("after_midrst_s_tready", 64'(bus.s_axis_vec_tready), 64'd1);
        check("after_midrst_tuser", 64'(bus.m_axis_result_tuser), 64'd0);
        check("midrst_beats_before", 64'(beat_cyc.size()), 64'd2);
        @(posedge aclk);
        #1;
        send_vec(rand_vec());
        drain();

        // Random downstream backpressure over many vectors.
        ready_rand = 1'b1;
        for (int k = 0; k < 100; k++) begin
            v = rand_vec();
            send_vec(v);
            idle($urandom_range(0, 3));
        end
        drain();
        ready_rand = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
